ps2_mouse_packet: RTL and testbench

Consumes the byte stream from the PS/2 controller (`received_data` / `received_data_en`) and assembles standard 3-byte mouse packets. For each packet it publishes button state and signed X/Y deltas, and maintains a clamped on-screen cursor position for the VGA/drawing logic. It also resynchronises on malformed or stalled packets.

---
 rtl/ps2_mouse_pkg.sv | 30 +++
 rtl/cursor_axis.sv | 47 ++++
 rtl/ps2_mouse_packet.sv | 174 +++++++++++++++++
 tb/tb_ps2_mouse_packet.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared types and byte-0 field layout for the PS/2 mouse packet assembler.
// Pure definitions: no logic, no latency.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    localparam logic [7:0] PS2_ACK = 8'hFA;

    localparam int B0_BTN_L = 0;
    localparam int B0_BTN_R = 1;
    localparam int B0_BTN_M = 2;
    localparam int B0_SYNC  = 3;
    localparam int B0_XSIGN = 4;
    localparam int B0_YSIGN = 5;
    localparam int B0_XOVF  = 6;
    localparam int B0_YOVF  = 7;

    // An overflowed axis reports no motion rather than a garbage delta.
    function automatic logic signed [8:0] axis_delta(input logic ovf,
                                                     input logic sign,
                                                     input logic [7:0] mag);
        return ovf ? 9'sd0 : $signed({sign, mag});
    endfunction

endpackage

// File: rtl/cursor_axis.sv
// One cursor coordinate: adds (or subtracts) a signed delta and clamps to 0..EXTENT-1.
// Position register updates on the edge where update_i is high; no backpressure.
module cursor_axis #(
    parameter int EXTENT = 160,
    parameter int W      = 8,
    parameter int START  = 80,
    parameter int SUM_W  = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic signed [8:0] delta_i,
    input  logic              negate_i,
    input  logic              update_i,
    output logic [W-1:0]      pos_o
);

    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(EXTENT - 1);

    logic [W-1:0]            pos_q, pos_d;
    logic signed [SUM_W-1:0] pos_ext, delta_ext, sum;

    assign pos_ext   = $signed({{(SUM_W-W){1'b0}}, pos_q});
    assign delta_ext = $signed({{(SUM_W-9){delta_i[8]}}, delta_i});
    assign sum       = negate_i ? (pos_ext - delta_ext) : (pos_ext + delta_ext);

    always_comb begin
        pos_d = pos_q;
        if (update_i) begin
            if (sum[SUM_W-1])
                pos_d = '0;
            else if (sum > MAX_S)
                pos_d = W'(EXTENT - 1);
            else
                pos_d = sum[W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            pos_q <= W'(START);
        else
            pos_q <= pos_d;
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/ps2_mouse_packet.sv
// Assembles 3-byte PS/2 mouse packets into buttons, deltas and a clamped cursor.
// Outputs update 2 edges after the b2 strobe; no backpressure, stalls/malformed starts resync.
module ps2_mouse_packet
    import ps2_mouse_pkg::*;
#(
    parameter int SCREEN_W       = 160,
    parameter int SCREEN_H       = 120,
    parameter int X_W            = 8,
    parameter int Y_W            = 7,
    parameter int START_X        = 80,
    parameter int START_Y        = 60,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [7:0]          received_data,
    input  logic                received_data_en,
    output logic                btn_left,
    output logic                btn_right,
    output logic                btn_middle,
    output logic signed [8:0]   dx,
    output logic signed [8:0]   dy,
    output logic [X_W-1:0]      cursor_x,
    output logic [Y_W-1:0]      cursor_y,
    output logic                packet_valid,
    output logic [7:0]          sync_errors
);

    localparam int SUM_W = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [2:0]      btn_bits_q;
    logic            xsign_q, ysign_q, xovf_q, yovf_q;
    logic [7:0]      b1_q, b2_q;
    logic            ld_b0, ld_b1, ld_b2, err_inc;
    logic [7:0]      err_q;
    logic            pv_q;
    logic            btn_l_q, btn_r_q, btn_m_q;
    logic signed [8:0] dx_q, dy_q, dx_new, dy_new;
    logic            do_update;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ld_b0   = 1'b0;
        ld_b1   = 1'b0;
        ld_b2   = 1'b0;
        err_inc = 1'b0;
        case (state_q)
            // UPDATE also screens an incoming byte as a packet start so it is not lost.
            WAIT_B0, UPDATE: begin
                state_d = WAIT_B0;
                if (received_data_en && received_data != PS2_ACK) begin
                    if (!received_data[B0_SYNC]) begin
                        err_inc = 1'b1;
                    end else begin
                        ld_b0   = 1'b1;
                        state_d = WAIT_B1;
                    end
                end
            end
            WAIT_B1, WAIT_B2: begin
                if (received_data_en) begin
                    ld_b1   = (state_q == WAIT_B1);
                    ld_b2   = (state_q == WAIT_B2);
                    state_d = (state_q == WAIT_B1) ? WAIT_B2 : UPDATE;
                end else if (cnt_q == TO_LAST) begin
                    err_inc = 1'b1;
                    state_d = WAIT_B0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = WAIT_B0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= WAIT_B0;
            cnt_q      <= '0;
            btn_bits_q <= '0;
            xsign_q    <= 1'b0;
            ysign_q    <= 1'b0;
            xovf_q     <= 1'b0;
            yovf_q     <= 1'b0;
            b1_q       <= '0;
            b2_q       <= '0;
            err_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ld_b0) begin
                btn_bits_q <= {received_data[B0_BTN_M], received_data[B0_BTN_R],
                               received_data[B0_BTN_L]};
                xsign_q    <= received_data[B0_XSIGN];
                ysign_q    <= received_data[B0_YSIGN];
                xovf_q     <= received_data[B0_XOVF];
                yovf_q     <= received_data[B0_YOVF];
            end
            if (ld_b1)
                b1_q <= received_data;
            if (ld_b2)
                b2_q <= received_data;
            if (err_inc && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end

    assign do_update = (state_q == UPDATE);
    assign dx_new    = axis_delta(xovf_q, xsign_q, b1_q);
    assign dy_new    = axis_delta(yovf_q, ysign_q, b2_q);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pv_q    <= 1'b0;
            btn_l_q <= 1'b0;
            btn_r_q <= 1'b0;
            btn_m_q <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
        end else begin
            pv_q <= do_update;
            if (do_update) begin
                btn_l_q <= btn_bits_q[0];
                btn_r_q <= btn_bits_q[1];
                btn_m_q <= btn_bits_q[2];
                dx_q    <= dx_new;
                dy_q    <= dy_new;
            end
        end
    end

    cursor_axis #(
        .EXTENT (SCREEN_W),
        .W      (X_W),
        .START  (START_X),
        .SUM_W  (SUM_W)
    ) u_axis_x (
        .clk_i    (CLOCK_50),
        .rst_ni   (resetn),
        .delta_i  (dx_new),
        .negate_i (1'b0),
        .update_i (do_update),
        .pos_o    (cursor_x)
    );

    // Mouse +Y is up, screen +Y is down, hence the subtraction.
    cursor_axis #(
        .EXTENT (SCREEN_H),
        .W      (Y_W),
        .START  (START_Y),
        .SUM_W  (SUM_W)
    ) u_axis_y (
        .clk_i    (CLOCK_50),
        .rst_ni   (resetn),
        .delta_i  (dy_new),
        .negate_i (1'b1),
        .update_i (do_update),
        .pos_o    (cursor_y)
    );

    assign btn_left     = btn_l_q;
    assign btn_right    = btn_r_q;
    assign btn_middle   = btn_m_q;
    assign dx           = dx_q;
    assign dy           = dy_q;
    assign packet_valid = pv_q;
    assign sync_errors  = err_q;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Directed bench for ps2_mouse_packet with a shortened packet timeout.
module tb_ps2_mouse_packet;

    localparam int T = 100;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rx_dat = 8'h00;
    logic       rx_vld = 1'b0;
    logic       btn_l, btn_r, btn_m;
    logic [8:0] dx, dy;
    logic [7:0] cx;
    logic [6:0] cy;
    logic       pv;
    logic [7:0] serr;

    int n_cmp = 0;
    int n_err = 0;
    int pv_cnt = 0;
    int pv_consec = 0;
    logic pv_prev = 1'b0;
    int pv_mark;

    always #10 clk = ~clk;

    ps2_mouse_packet #(
        .SCREEN_W(160), .SCREEN_H(120), .X_W(8), .Y_W(7),
        .START_X(80), .START_Y(60), .TIMEOUT_CYCLES(T)
    ) dut (
        .CLOCK_50         (clk),
        .resetn           (resetn),
        .received_data    (rx_dat),
        .received_data_en (rx_vld),
        .btn_left         (btn_l),
        .btn_right        (btn_r),
        .btn_middle       (btn_m),
        .dx               (dx),
        .dy               (dy),
        .cursor_x         (cx),
        .cursor_y         (cy),
        .packet_valid     (pv),
        .sync_errors      (serr)
    );

    always @(negedge clk) begin
        if (pv) begin
            pv_cnt = pv_cnt + 1;
            if (pv_prev) pv_consec = pv_consec + 1;
        end
        pv_prev = pv;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the strobe is sampled by the following posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_dat = b;
        rx_vld = 1'b1;
        @(negedge clk);
        rx_vld = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        chk("rst_pv", {31'd0, pv}, 32'd0);
        chk("rst_cx", {24'd0, cx}, 32'd80);
        chk("rst_cy", {25'd0, cy}, 32'd60);
        chk("rst_dx", {23'd0, dx}, 32'd0);
        chk("rst_serr", {24'd0, serr}, 32'd0);
        chk("rst_btn", {29'd0, btn_m, btn_r, btn_l}, 32'd0);

        // Basic packet, with an exact check of the one-edge UPDATE timing.
        pv_mark = pv_cnt;
        send_pkt(8'h08, 8'h05, 8'h03);
        chk("p1_pv_early", {31'd0, pv}, 32'd0);
        @(negedge clk);
        chk("p1_pv_pulse", {31'd0, pv}, 32'd1);
        settle();
        chk("p1_pv_cnt", pv_cnt - pv_mark, 32'd1);
        chk("p1_dx", {23'd0, dx}, 32'h005);
        chk("p1_dy", {23'd0, dy}, 32'h003);
        chk("p1_cx", {24'd0, cx}, 32'd85);
        chk("p1_cy", {25'd0, cy}, 32'd57);
        chk("p1_btn", {29'd0, btn_m, btn_r, btn_l}, 32'd0);

        // ACK then negative deltas with left button.
        do_reset();
        send_byte(8'hFA);
        send_pkt(8'h39, 8'hFB, 8'hFE);
        settle();
        chk("ack_serr", {24'd0, serr}, 32'd0);
        chk("p2_btn", {29'd0, btn_m, btn_r, btn_l}, 32'd1);
        chk("p2_dx", {23'd0, dx}, 32'h1FB);
        chk("p2_dy", {23'd0, dy}, 32'h1FE);
        chk("p2_cx", {24'd0, cx}, 32'd75);
        chk("p2_cy", {25'd0, cy}, 32'd62);

        // Clamping at all four edges.
        do_reset();
        send_pkt(8'h08, 8'h4F, 8'h00);
        settle();
        chk("clx_exact", {24'd0, cx}, 32'd159);
        send_pkt(8'h08, 8'h7F, 8'h00);
        settle();
        chk("clx_hi", {24'd0, cx}, 32'd159);
        send_pkt(8'h28, 8'h00, 8'h7F);
        settle();
        chk("cly_dy", {23'd0, dy}, 32'h17F);
        chk("cly_hi1", {25'd0, cy}, 32'd119);
        send_pkt(8'h28, 8'h00, 8'h7F);
        settle();
        chk("cly_hi2", {25'd0, cy}, 32'd119);
        send_pkt(8'h18, 8'h80, 8'h00);
        settle();
        chk("clx_mid", {24'd0, cx}, 32'd31);
        send_pkt(8'h18, 8'h80, 8'h00);
        settle();
        chk("clx_lo", {24'd0, cx}, 32'd0);
        send_pkt(8'h08, 8'h00, 8'h7F);
        settle();
        chk("cly_lo", {25'd0, cy}, 32'd0);

        // Bad sync byte then recovery.
        do_reset();
        send_byte(8'h02);
        send_pkt(8'h08, 8'h01, 8'h01);
        settle();
        chk("bad_serr", {24'd0, serr}, 32'd1);
        chk("bad_dx", {23'd0, dx}, 32'h001);
        chk("bad_dy", {23'd0, dy}, 32'h001);
        chk("bad_cx", {24'd0, cx}, 32'd81);
        chk("bad_cy", {25'd0, cy}, 32'd59);

        // Timeout boundary: a byte in the last allowed cycle is accepted.
        do_reset();
        send_byte(8'h08);
        repeat (T - 1) @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h00);
        settle();
        chk("to_edge_serr", {24'd0, serr}, 32'd0);
        chk("to_edge_cx", {24'd0, cx}, 32'd81);
        // One cycle later the packet is dropped and the stray byte is rejected too.
        pv_mark = pv_cnt;
        send_byte(8'h08);
        repeat (T) @(negedge clk);
        send_byte(8'h01);
        settle();
        chk("to_serr", {24'd0, serr}, 32'd2);
        chk("to_no_pv", pv_cnt - pv_mark, 32'd0);
        send_pkt(8'h08, 8'h01, 8'h00);
        settle();
        chk("to_after_cx", {24'd0, cx}, 32'd82);

        // Overflow flags.
        do_reset();
        send_pkt(8'h48, 8'hFF, 8'h02);
        settle();
        chk("xovf_dx", {23'd0, dx}, 32'h000);
        chk("xovf_dy", {23'd0, dy}, 32'h002);
        chk("xovf_cy", {25'd0, cy}, 32'd58);
        send_pkt(8'h88, 8'h01, 8'h05);
        settle();
        chk("yovf_dx", {23'd0, dx}, 32'h001);
        chk("yovf_dy", {23'd0, dy}, 32'h000);

        // Back-to-back packets: first byte of the second lands in the UPDATE cycle.
        pv_mark = pv_cnt;
        send_pkt(8'h08, 8'h01, 8'h00);
        send_pkt(8'h08, 8'h01, 8'h00);
        settle();
        chk("b2b_pv_cnt", pv_cnt - pv_mark, 32'd2);
        chk("b2b_cx", {24'd0, cx}, 32'd83);

        // Reset in the middle of a packet.
        send_pkt(8'h08, 8'h05, 8'h05);
        settle();
        pv_mark = pv_cnt;
        send_byte(8'h08);
        send_byte(8'h10);
        resetn = 1'b0;
        #1;
        chk("mid_rst_cx", {24'd0, cx}, 32'd80);
        chk("mid_rst_cy", {25'd0, cy}, 32'd60);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_rst_no_pv", pv_cnt - pv_mark, 32'd0);
        send_pkt(8'h08, 8'h02, 8'h00);
        settle();
        chk("mid_rst_after", {24'd0, cx}, 32'd82);

        // Error counter saturation.
        do_reset();
        for (int i = 0; i < 260; i++) send_byte(8'h00);
        settle();
        chk("serr_sat", {24'd0, serr}, 32'd255);

        chk("pv_never_consec", pv_consec, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
